// File: rtl/uart_rx_fifo_ctrl.sv
// 16-entry UART receive FIFO: stores {FE,PE,data}, generates level/timeout/error status,
// and serves RBR (data pop) and LSR (status) reads on the DSP bus.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int TO_TICKS = 640
) (
  input  logic        DSP_CLK,
  input  logic        RESETn,
  input  logic        BaudTick16,
  input  logic        RxWrEn,
  input  logic [7:0]  RxWrData,
  input  logic        RxWrPE,
  input  logic        RxWrFE,
  input  logic        DSP_CEn,
  input  logic [3:0]  DSP_ADDR,
  input  logic        DSP_WEn,
  output logic [31:0] DSP_RDATA,
  output logic        RxFIFO_Empty,
  output logic        RxFIFO_L2_Full,
  output logic        RxFIFO_L4_Full,
  output logic        RxFIFO_L8_Full,
  output logic        RxFIFO_L12_Full,
  output logic        RxFIFO_L14_Full,
  output logic        RxTimeOut,
  output logic        ParityError,
  output logic        FrameError,
  output logic        OverrunError
);

  localparam logic [4:0] FULL_CNT = 5'(DEPTH);
  localparam logic [9:0] TO_MAX   = 10'(TO_TICKS);
  localparam logic [3:0] ADDR_RBR = 4'b0000;
  localparam logic [3:0] ADDR_LSR = 4'b0001;

  logic [9:0]  mem [16];
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        ovr_q, ovr_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_acc_q;

  logic        rd_acc_s;
  logic        rd_ev_s;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_ok_s;
  logic        ovr_set_s;
  logic [9:0]  head_s;

  assign rd_acc_s  = ~DSP_CEn & DSP_WEn;
  // One access event per chip-enable-low burst.
  assign rd_ev_s   = rd_acc_s & ~rd_acc_q;
  assign empty_s   = (count_q == 5'd0);
  assign full_s    = (count_q == FULL_CNT);
  assign head_s    = mem[rd_ptr_q];
  assign pop_s     = rd_ev_s & (DSP_ADDR == ADDR_RBR) & ~empty_s;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok_s = RxWrEn & (~full_s | pop_s);
  assign ovr_set_s = RxWrEn & full_s & ~pop_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    to_cnt_d = to_cnt_q;
    rdata_d  = rdata_q;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + 4'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 4'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // Overrun set takes priority over the LSR read clear.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (rd_ev_s && (DSP_ADDR == ADDR_LSR)) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (RxWrEn || pop_s || empty_s) begin
      to_cnt_d = 10'd0;
    end else if (BaudTick16 && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + 10'd1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (rd_ev_s) begin
      case (DSP_ADDR)
        ADDR_RBR: rdata_d = empty_s ? 32'd0 : {24'd0, head_s[7:0]};
        ADDR_LSR: rdata_d = {28'd0, (~empty_s & head_s[9]), (~empty_s & head_s[8]),
                             ovr_q, ~empty_s};
        default:  rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
      ovr_q    <= 1'b0;
      to_cnt_q <= 10'd0;
      rdata_q  <= 32'd0;
      rd_acc_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      to_cnt_q <= to_cnt_d;
      rdata_q  <= rdata_d;
      rd_acc_q <= rd_acc_s;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge DSP_CLK) begin
    if (push_ok_s) begin
      mem[wr_ptr_q] <= {RxWrFE, RxWrPE, RxWrData};
    end
  end

  assign DSP_RDATA       = rdata_q;
  assign OverrunError    = ovr_q;
  assign RxFIFO_Empty    = empty_s;
  assign RxFIFO_L2_Full  = (count_q >= 5'd2);
  assign RxFIFO_L4_Full  = (count_q >= 5'd4);
  assign RxFIFO_L8_Full  = (count_q >= 5'd8);
  assign RxFIFO_L12_Full = (count_q >= 5'd12);
  assign RxFIFO_L14_Full = (count_q >= 5'd14);
  assign ParityError     = ~empty_s & head_s[8];
  assign FrameError      = ~empty_s & head_s[9];
  assign RxTimeOut       = (to_cnt_q == TO_MAX) & ~empty_s;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: queue-based reference model compared every cycle,
// plus directed literal checks on levels, overrun, timeout, error bits and reset.
module tb_uart_rx_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_pe;
  logic        wr_fe;
  logic        cen;
  logic [3:0]  addr;
  logic        wen;
  logic [31:0] rdata;
  logic        empty, l2, l4, l8, l12, l14, tmo, pe, fe, ovr;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo_ctrl dut (
    .DSP_CLK(clk), .RESETn(rst_n), .BaudTick16(tick),
    .RxWrEn(wr_en), .RxWrData(wr_data), .RxWrPE(wr_pe), .RxWrFE(wr_fe),
    .DSP_CEn(cen), .DSP_ADDR(addr), .DSP_WEn(wen), .DSP_RDATA(rdata),
    .RxFIFO_Empty(empty), .RxFIFO_L2_Full(l2), .RxFIFO_L4_Full(l4),
    .RxFIFO_L8_Full(l8), .RxFIFO_L12_Full(l12), .RxFIFO_L14_Full(l14),
    .RxTimeOut(tmo), .ParityError(pe), .FrameError(fe), .OverrunError(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {FE,PE,data} plus sticky/overrun, idle timer and read register.
  logic [9:0]  m_q[$];
  logic        m_ovr;
  int          m_to;
  logic [31:0] m_rdata;
  logic        m_prev_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovr = 1'b0;
      m_to = 0;
      m_rdata = 32'd0;
      m_prev_acc = 1'b0;
    end else begin
      logic acc, ev, do_pop, was_full, was_empty;
      acc       = !cen && wen;
      ev        = acc && !m_prev_acc;
      m_prev_acc = acc;
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == 16);
      do_pop    = ev && (addr == 4'd0) && !was_empty;
      if (ev) begin
        if (addr == 4'd0)
          m_rdata = was_empty ? 32'd0 : {24'd0, m_q[0][7:0]};
        else if (addr == 4'd1)
          m_rdata = {28'd0, (!was_empty && m_q[0][9]), (!was_empty && m_q[0][8]), m_ovr, !was_empty};
        else
          m_rdata = 32'd0;
        if (addr == 4'd1) m_ovr = 1'b0;
      end
      if (wr_en && was_full && !do_pop) m_ovr = 1'b1;
      if (wr_en || do_pop || was_empty) m_to = 0;
      else if (tick && m_to < 640) m_to = m_to + 1;
      if (do_pop) void'(m_q.pop_front());
      if (wr_en && (!was_full || do_pop)) m_q.push_back({wr_fe, wr_pe, wr_data});
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int sz;
      sz = m_q.size();
      chk("rdata", rdata, m_rdata);
      chk("empty", {31'd0, empty}, {31'd0, sz == 0});
      chk("levels", {27'd0, l14, l12, l8, l4, l2},
          {27'd0, sz >= 14, sz >= 12, sz >= 8, sz >= 4, sz >= 2});
      chk("pe_fe", {30'd0, fe, pe},
          {30'd0, (sz != 0) && m_q[0][9], (sz != 0) && m_q[0][8]});
      chk("overrun", {31'd0, ovr}, {31'd0, m_ovr});
      chk("timeout", {31'd0, tmo}, {31'd0, (m_to == 640) && (sz != 0)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    wr_en = 1'b1; wr_data = d; wr_pe = p; wr_fe = f;
    step();
    wr_en = 1'b0; wr_pe = 1'b0; wr_fe = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    cen = 1'b0; wen = 1'b1; addr = a;
    step();
    cen = 1'b1;
    step();
  endtask

  task automatic baud();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_data = 8'd0; wr_pe = 1'b0; wr_fe = 1'b0;
    cen = 1'b1; addr = 4'd0; wen = 1'b1;
    step(); step();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_levels", {27'd0, l14, l12, l8, l4, l2}, 32'd0);
    chk("rst_tmo_ovr", {30'd0, tmo, ovr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Fill 16 and watch the level thresholds, then drain in order.
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0, 1'b0);
      chk("fill_levels", {27'd0, l14, l12, l8, l4, l2},
          {27'd0, i + 1 >= 14, i + 1 >= 12, i + 1 >= 8, i + 1 >= 4, i + 1 >= 2});
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'd0);
      chk("drain_data", rdata, 32'(i));
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    rd(4'd0);
    chk("pop_on_empty", rdata, 32'd0);

    // Overrun: 17th char is dropped; LSR reports then clears it.
    for (int i = 0; i < 17; i++) push(8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    rd(4'd1);
    chk("lsr_ovr", rdata, 32'h3);
    chk("ovr_clr", {31'd0, ovr}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'd0);
      chk("ovr_drain", rdata, 32'hA0 + 32'(i));
    end
    chk("ovr_drain_empty", {31'd0, empty}, 32'd1);

    // Push and pop in the same cycle while full: no overrun, count stays 16.
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 8'hEE; cen = 1'b0; addr = 4'd0;
    step();
    wr_en = 1'b0; cen = 1'b1;
    chk("pp_data", rdata, 32'h40);
    chk("pp_no_ovr", {31'd0, ovr}, 32'd0);
    chk("pp_l14", {31'd0, l14}, 32'd1);
    step();
    for (int i = 0; i < 16; i++) rd(4'd0);
    chk("pp_last", rdata, 32'hEE);

    // Timeout after exactly 640 ticks with one char waiting.
    push(8'h11, 1'b0, 1'b0);
    for (int i = 1; i <= 640; i++) begin
      baud();
      if (i == 639) chk("tmo_639", {31'd0, tmo}, 32'd0);
      if (i == 640) chk("tmo_640", {31'd0, tmo}, 32'd1);
    end
    rd(4'd0);
    chk("tmo_read", rdata, 32'h11);
    chk("tmo_drop", {31'd0, tmo}, 32'd0);
    for (int i = 0; i < 700; i++) baud();
    chk("tmo_empty", {31'd0, tmo}, 32'd0);

    // Parity error reporting.
    push(8'h55, 1'b1, 1'b0);
    chk("pe_set", {31'd0, pe}, 32'd1);
    rd(4'd1);
    chk("lsr_pe", rdata, 32'h5);
    rd(4'd0);
    chk("pe_data", rdata, 32'h55);
    chk("pe_clr", {31'd0, pe}, 32'd0);

    // CEn held low 3 cycles gives a single pop.
    push(8'h21, 1'b0, 1'b1);
    push(8'h22, 1'b0, 1'b0);
    chk("fe_set", {31'd0, fe}, 32'd1);
    cen = 1'b0; addr = 4'd0;
    step(); step(); step();
    cen = 1'b1;
    step();
    chk("burst_data", rdata, 32'h21);
    chk("burst_one_pop", {31'd0, empty}, 32'd0);
    rd(4'd0);
    chk("burst_second", rdata, 32'h22);

    // Asynchronous reset with 9 entries and a partially run timer.
    for (int i = 0; i < 9; i++) push(8'h70 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) baud();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_levels", {27'd0, l14, l12, l8, l4, l2}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_tmo_pe", {29'd0, tmo, pe, fe}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push(8'h99, 1'b0, 1'b0);
    rd(4'd0);
    chk("post_rst_data", rdata, 32'h99);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
